// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive path.
package i2s_pkg;

  localparam int unsigned MAX_TDM = 16;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StRun,
    StDrain
  } state_e;

  // Highest enabled slot index below tdm; this slot carries tlast downstream.
  function automatic logic [3:0] hi_slot(logic [15:0] mask, logic [4:0] tdm);
    logic [3:0] hi;
    hi = '0;
    for (int i = 0; i < 16; i++) begin
      if (mask[i] && (5'(i) < tdm)) hi = 4'(i);
    end
    return hi;
  endfunction

endpackage

// File: rtl/i2s_axis_reg.sv
// One-entry output register with ready/valid handshake; refills in the same cycle it drains.
module i2s_axis_reg #(
  parameter int unsigned Width = 37
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [Width-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [Width-1:0] out_data_o,
  input  logic             out_ready_i
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/i2s_rx_ctrl.sv
// I2S/TDM receive controller: frame alignment, slot masking and run control over a PHY word stream.
module i2s_rx_ctrl #(
  parameter int unsigned MAX_TDM = i2s_pkg::MAX_TDM,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               bclk,
  input  logic               rst_n,
  input  logic               cfg_start,
  input  logic               cfg_stop,
  input  logic [CNT_W-1:0]   cfg_frame_limit,
  input  logic [4:0]         cfg_tdm_num,
  input  logic [MAX_TDM-1:0] cfg_chan_mask,
  output logic               phy_enable,
  input  logic               s_axis_tvalid,
  input  logic [31:0]        s_axis_tdata,
  input  logic               s_axis_tlast,
  output logic               m_axis_tvalid,
  output logic [31:0]        m_axis_tdata,
  output logic               m_axis_tlast,
  output logic [3:0]         m_axis_tuser,
  input  logic               m_axis_tready,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   frame_count,
  output logic               err_len,
  output logic               err_ovf
);
  import i2s_pkg::*;

  localparam logic [4:0] TdmMax = 5'(MAX_TDM);

  logic [1:0]       rst_sync_q;
  logic             rst_sync_n;
  state_e           state_q;
  logic [CNT_W-1:0] limit_q, count_q, count_inc;
  logic [4:0]       tdm_q, tdm_eff;
  logic [15:0]      mask_q;
  logic [3:0]       idx_q, last_idx, hi_idx;
  logic             stop_q, phy_q, done_q, err_len_q, err_ovf_q;
  logic             word_run, fwd, reg_ready, stop_any, limit_hit;
  logic [36:0]      reg_out;

  // Assert immediately, release two bclk edges after rst_n rises.
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_sync_n = rst_sync_q[1];

  assign tdm_eff   = (cfg_tdm_num == 5'd0) ? 5'd1 :
                     (cfg_tdm_num > TdmMax) ? TdmMax : cfg_tdm_num;
  assign last_idx  = 4'(tdm_q - 5'd1);
  assign hi_idx    = hi_slot(mask_q, tdm_q);
  assign word_run  = (state_q == StRun) && s_axis_tvalid;
  assign fwd       = word_run && mask_q[idx_q];
  assign stop_any  = stop_q || cfg_stop;
  assign count_inc = (count_q == '1) ? count_q : count_q + 1'b1;
  assign limit_hit = (limit_q != '0) && (count_inc == limit_q);

  i2s_axis_reg #(
    .Width(37)
  ) u_out_reg (
    .clk_i      (bclk),
    .rst_ni     (rst_sync_n),
    .in_valid_i (fwd),
    .in_data_i  ({s_axis_tdata, idx_q == hi_idx, idx_q}),
    .in_ready_o (reg_ready),
    .out_valid_o(m_axis_tvalid),
    .out_data_o (reg_out),
    .out_ready_i(m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tlast, m_axis_tuser} = reg_out;

  always_ff @(posedge bclk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q   <= StIdle;
      limit_q   <= '0;
      tdm_q     <= 5'd1;
      mask_q    <= '0;
      idx_q     <= '0;
      stop_q    <= 1'b0;
      phy_q     <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
      err_len_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cfg_start) begin
            limit_q   <= cfg_frame_limit;
            tdm_q     <= tdm_eff;
            mask_q    <= 16'(cfg_chan_mask);
            idx_q     <= '0;
            stop_q    <= 1'b0;
            count_q   <= '0;
            err_len_q <= 1'b0;
            err_ovf_q <= 1'b0;
            phy_q     <= 1'b1;
            state_q   <= StArm;
          end
        end
        StArm: begin
          if (cfg_stop) begin
            state_q <= StIdle;
            stop_q  <= 1'b0;
            phy_q   <= 1'b0;
            done_q  <= 1'b1;
          end else if (s_axis_tvalid && s_axis_tlast) begin
            idx_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (cfg_stop) stop_q <= 1'b1;
          if (fwd && !reg_ready) err_ovf_q <= 1'b1;
          if (s_axis_tvalid) begin
            if (s_axis_tlast) begin
              idx_q <= '0;
              if (idx_q == last_idx) begin
                count_q <= count_inc;
                if (limit_hit || stop_any) begin
                  state_q <= StDrain;
                  phy_q   <= 1'b0;
                end
              end else begin
                err_len_q <= 1'b1;
                if (stop_any) begin
                  state_q <= StDrain;
                  phy_q   <= 1'b0;
                end
              end
            end else if (idx_q == last_idx) begin
              err_len_q <= 1'b1;
              idx_q     <= '0;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        StDrain: begin
          if (!m_axis_tvalid) begin
            state_q <= StIdle;
            stop_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign phy_enable  = phy_q;
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign frame_count = count_q;
  assign err_len     = err_len_q;
  assign err_ovf     = err_ovf_q;

endmodule

// File: doc/i2s_rx_ctrl.md
I2S_RX_CTRL -- requirements
Module: i2s_rx_ctrl

Interface
REQ-001 Parameter MAX_TDM, default 16: maximum TDM slots per frame; sets the width of cfg_chan_mask.
REQ-002 Parameter CNT_W, default 32: width of the frame counter and of cfg_frame_limit.
REQ-003 bclk  in  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 cfg_start  in  1  single-cycle pulse; starts a capture run.
REQ-006 cfg_stop  in  1  single-cycle pulse; requests a stop at the next frame boundary.
REQ-007 cfg_frame_limit  in  CNT_W  frames per run; 0 means unlimited.
REQ-008 cfg_tdm_num  in  5  slots per frame, valid range 1..16; 0 SHALL be treated as 1.
REQ-009 cfg_chan_mask  in  MAX_TDM  bit k=1 forwards slot k.
REQ-010 phy_enable  out  1  enable to the I2S input PHY.
REQ-011 s_axis_tvalid/s_axis_tdata/s_axis_tlast  in  1/32/1  word stream from the PHY; no ready.
REQ-012 m_axis_tvalid/m_axis_tdata/m_axis_tlast/m_axis_tuser  out  1/32/1/4  forwarded words; tuser = slot index.
REQ-013 m_axis_tready  in  1  downstream ready.
REQ-014 busy  out  1  high whenever the state is not IDLE.
REQ-015 done  out  1  one-cycle pulse at the end of a run.
REQ-016 frame_count  out  CNT_W  number of frames completed in the current or last run.
REQ-017 err_len  out  1  sticky: frame length mismatch.
REQ-018 err_ovf  out  1  sticky: word dropped due to backpressure.

Function
REQ-019 The FSM SHALL have four states: IDLE, ARM, RUN, DRAIN.
REQ-020 IDLE: phy_enable=0; on cfg_start, latch all cfg_* inputs, clear frame_count, err_len, err_ovf and the slot index, then go to ARM.
REQ-021 cfg_start outside IDLE SHALL be ignored; cfg_* changes after the latch SHALL have no effect until the next run.
REQ-022 ARM: phy_enable=1; discard all words; on a word with tlast, go to RUN with slot index 0.
REQ-023 cfg_stop in ARM SHALL go to IDLE next cycle, pulse done, and drive phy_enable=0.
REQ-024 RUN: each valid input word SHALL carry slot index idx; idx increments per word and resets to 0 after a tlast word.
REQ-025 Word with idx=tdm_num-1 and no tlast: set err_len and wrap idx to 0.
REQ-026 Word with tlast and idx!=tdm_num-1: set err_len and do not count the frame.
REQ-027 Word with tlast and idx=tdm_num-1: increment frame_count, saturating at all-ones.
REQ-028 Forward a word only if cfg_chan_mask[idx]=1.
REQ-029 m_axis_tlast=1 only on the highest-indexed enabled slot below tdm_num.
REQ-030 Latency: an input word at edge N SHALL appear on m_axis at edge N+1 through a one-entry output register.
REQ-031 tvalid SHALL hold, with stable data, until the cycle after tready is sampled high.
REQ-032 Simultaneous output and new word with tready=1: accept the new word in the same cycle with no bubble.
REQ-033 New forwardable word while the output register is full and tready=0: drop the word, set err_ovf, and still advance idx.
REQ-034 At a counted frame end, go to DRAIN and set phy_enable=0 if frame_count reaches a nonzero cfg_frame_limit or a stop is pending.
REQ-035 cfg_stop in RUN SHALL set stop_pending; stop_pending is cleared on entry to IDLE.
REQ-036 A length-error frame end with a stop pending SHALL also go to DRAIN.
REQ-037 DRAIN: discard input; when the output register is empty, go to IDLE and pulse done.
REQ-038 Masks with no slot enabled are legal: nothing is forwarded, and frames are still counted.

Reset
REQ-039 rst_n low SHALL asynchronously force IDLE with all outputs 0 and all counters, flags and stop_pending cleared.
REQ-040 Reset mid-run SHALL discard the word in the output register; the deassertion edge SHALL be synchronized inside the block.

Structure
REQ-041 The FSM state encoding and MAX_TDM SHALL live in shared package i2s_pkg.
REQ-042 The output register/handshake SHALL be a sub-module, i2s_axis_reg (1-entry, 37-bit payload).

Verification
REQ-043 tdm=4, mask=0xF, limit=3, tready=1, start mid-frame: partial frame dropped, 12 words out with tuser 0..3, tlast on slot 3, frame_count=3, done pulse, phy_enable=0.
REQ-044 tdm=8, mask=0x05: only slots 0 and 2 forwarded; tlast on slot 2.
REQ-045 tdm=4, inject tlast at idx 2: err_len=1, frame not counted, next frame realigns at idx 0.
REQ-046 tready=0 for 3 words: first word held stable, the next words are dropped, err_ovf=1.
REQ-047 limit=0, cfg_stop mid-frame: frame completes and is counted, DRAIN, then IDLE with done.
REQ-048 rst_n low during RUN with m_axis_tvalid=1: all outputs 0 immediately; a fresh start works.
